mips_cache_wbuf_coalesce: RTL

//  Parametrised successor of the cache write buffer: posted-write FIFO between data cache and

---
 rtl/mips_cache_wbuf_coalesce.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/mips_cache_wbuf_coalesce.sv
// Posted-write buffer between the data cache and Avalon-MM memory, with same-word
// write coalescing, read forwarding for the miss path, and an occupancy count.
module mips_cache_wbuf_coalesce #(
  parameter int BUF_BITS = 3,
  parameter bit COALESCE = 1'b1,
  parameter bit FORWARD  = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         addr,
  input  logic                write_en,
  input  logic [31:0]         writedata,
  input  logic [3:0]          byteenable,
  output logic                full,
  output logic                empty,
  output logic [BUF_BITS:0]   count,
  input  logic [31:0]         lookup_addr,
  output logic                lookup_hit,
  output logic [31:0]         lookup_data,
  output logic [3:0]          lookup_byteenable,
  output logic [31:0]         write_addr,
  output logic [31:0]         write_data,
  output logic [3:0]          write_byteenable,
  output logic                write_writeenable,
  input  logic                waitrequest
);

  localparam int DEPTH = 1 << BUF_BITS;
  localparam logic [BUF_BITS:0] DEPTH_C = {1'b1, {BUF_BITS{1'b0}}};

  typedef enum logic {S_IDLE = 1'b0, S_WRITE = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [29:0]           word_q [DEPTH];
  logic [29:0]           word_d [DEPTH];
  logic [31:0]           data_q [DEPTH];
  logic [31:0]           data_d [DEPTH];
  logic [3:0]            be_q   [DEPTH];
  logic [3:0]            be_d   [DEPTH];
  logic [BUF_BITS-1:0]   head_q, head_d, tail_q, tail_d;
  logic [BUF_BITS:0]     count_q, count_d;
  logic [31:0]           waddr_q, waddr_d, wdata_q, wdata_d;
  logic [3:0]            wbe_q, wbe_d;
  logic                  wwe_q, wwe_d;

  logic                  enq_s, merge_hit_s, do_merge_s, alloc_s, pop_s;
  logic [BUF_BITS-1:0]   merge_idx_s, lk_idx_s;

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    lane_mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  assign full              = (count_q == DEPTH_C);
  assign empty             = (count_q == {(BUF_BITS+1){1'b0}});
  assign count             = count_q;
  assign write_addr        = waddr_q;
  assign write_data        = wdata_q;
  assign write_byteenable  = wbe_q;
  assign write_writeenable = wwe_q;

  // The head entry is locked while it is being presented on the bus.
  always_comb begin
    merge_hit_s = 1'b0;
    merge_idx_s = {BUF_BITS{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      if (COALESCE && valid_q[i] && (word_q[i] == addr[31:2]) &&
          !((state_q == S_WRITE) && (head_q == BUF_BITS'(i)))) begin
        merge_hit_s = 1'b1;
        merge_idx_s = BUF_BITS'(i);
      end else begin
        merge_hit_s = merge_hit_s;
      end
    end
  end

  assign enq_s      = write_en && (byteenable != 4'b0000);
  assign do_merge_s = enq_s && merge_hit_s;
  assign alloc_s    = enq_s && !merge_hit_s && !full;
  assign pop_s      = (state_q == S_WRITE) && !waitrequest;

  // Entry updates, pointers, and drain FSM; bus registers load from post-update entries.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    word_d  = word_q;
    data_d  = data_q;
    be_d    = be_q;
    head_d  = head_q;
    tail_d  = tail_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    wbe_d   = wbe_q;
    wwe_d   = wwe_q;
    if (do_merge_s) begin
      for (int b = 0; b < 4; b++) begin
        if (byteenable[b]) begin
          data_d[merge_idx_s][8*b +: 8] = writedata[8*b +: 8];
        end else begin
          data_d[merge_idx_s][8*b +: 8] = data_q[merge_idx_s][8*b +: 8];
        end
      end
      be_d[merge_idx_s] = be_q[merge_idx_s] | byteenable;
    end else begin
      be_d = be_d;
    end
    if (alloc_s) begin
      valid_d[tail_q] = 1'b1;
      word_d[tail_q]  = addr[31:2];
      data_d[tail_q]  = writedata & lane_mask(byteenable);
      be_d[tail_q]    = byteenable;
      tail_d          = tail_q + BUF_BITS'(1);
    end else begin
      tail_d = tail_q;
    end
    if (pop_s) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + BUF_BITS'(1);
    end else begin
      head_d = head_q;
    end
    count_d = count_q + {{BUF_BITS{1'b0}}, alloc_s} - {{BUF_BITS{1'b0}}, pop_s};
    case (state_q)
      S_IDLE: begin
        if (count_q != {(BUF_BITS+1){1'b0}}) begin
          state_d = S_WRITE;
          wwe_d   = 1'b1;
          waddr_d = {word_d[head_q], 2'b00};
          wdata_d = data_d[head_q];
          wbe_d   = be_d[head_q];
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        if (pop_s && (count_d != {(BUF_BITS+1){1'b0}})) begin
          waddr_d = {word_d[head_d], 2'b00};
          wdata_d = data_d[head_d];
          wbe_d   = be_d[head_d];
        end else if (pop_s) begin
          state_d = S_IDLE;
          wwe_d   = 1'b0;
        end else begin
          state_d = S_WRITE;
        end
      end
      default: begin
        state_d = S_IDLE;
        wwe_d   = 1'b0;
      end
    endcase
  end

  // Scan oldest to youngest so the newest match (the unlocked one) wins.
  always_comb begin
    lookup_hit        = 1'b0;
    lookup_data       = 32'h0000_0000;
    lookup_byteenable = 4'b0000;
    lk_idx_s          = {BUF_BITS{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      lk_idx_s = head_q + BUF_BITS'(i);
      if (FORWARD && ({1'b0, BUF_BITS'(i)} < count_q) && valid_q[lk_idx_s] &&
          (word_q[lk_idx_s] == lookup_addr[31:2])) begin
        lookup_hit        = 1'b1;
        lookup_data       = data_q[lk_idx_s];
        lookup_byteenable = be_q[lk_idx_s];
      end else begin
        lookup_hit = lookup_hit;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      valid_q <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        word_q[i] <= 30'h0;
        data_q[i] <= 32'h0;
        be_q[i]   <= 4'h0;
      end
      head_q  <= {BUF_BITS{1'b0}};
      tail_q  <= {BUF_BITS{1'b0}};
      count_q <= {(BUF_BITS+1){1'b0}};
      waddr_q <= 32'h0;
      wdata_q <= 32'h0;
      wbe_q   <= 4'h0;
      wwe_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      word_q  <= word_d;
      data_q  <= data_d;
      be_q    <= be_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      wbe_q   <= wbe_d;
      wwe_q   <= wwe_d;
    end
  end

endmodule
